// File: rtl/raster_frame_buffer.sv
// Captures the triangle engine's pixel stream into a 2**W x 2**W bitmap, then
// scans it out row by row over valid/ready once the triangle ends.
module raster_frame_buffer #(
    parameter int W     = 3,
    parameter bit ACCUM = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               po,
    input  logic [W-1:0]       xo,
    input  logic [W-1:0]       yo,
    input  logic               busy,
    input  logic               row_ready,
    output logic               row_valid,
    output logic [2**W-1:0]    row_data,
    output logic [W-1:0]       row_idx,
    output logic [2*W:0]       pix_cnt,
    output logic               frame_done,
    output logic               stall,
    output logic               dup_err,
    output logic               ovf_err
);
    localparam int N  = 2**W;
    localparam int CW = 2*W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, CLEAR} state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   bitmap [N];
    logic           busy_d;
    logic           eot;
    logic           accept;
    logic           hit;
    logic           xfer;
    logic           last_row;

    // Handshake: a row moves on any rising edge where row_valid and row_ready
    // are both high; row_valid never drops until that row has moved.
    assign eot       = busy_d & ~busy;
    assign accept    = po & ~stall;
    assign hit       = bitmap[yo][xo];
    assign row_valid = (state == SCAN);
    assign row_data  = row_valid ? bitmap[row_idx] : '0;
    assign xfer      = row_valid & row_ready;
    assign last_row  = (row_idx == W'(N - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (busy) state_next = COLLECT;
            COLLECT: if (eot) state_next = SCAN;
            SCAN:    if (xfer && last_row) state_next = ACCUM ? IDLE : CLEAR;
            CLEAR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stall      <= 1'b0;
            busy_d     <= 1'b0;
            frame_done <= 1'b0;
            row_idx    <= '0;
            pix_cnt    <= '0;
            dup_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_next;
            // Registered from next-state so it is already high in the first SCAN cycle.
            stall      <= (state_next == SCAN) || (state_next == CLEAR);
            busy_d     <= busy;
            frame_done <= xfer && last_row;
            if (state == COLLECT && eot) begin
                row_idx <= '0;
            end else if (xfer) begin
                row_idx <= row_idx + W'(1);
            end
            if (state == CLEAR) begin
                pix_cnt <= '0;
            end else if (accept && !hit) begin
                pix_cnt <= pix_cnt + CW'(1);
            end
            if (accept && hit) dup_err <= 1'b1;
            if (po && stall) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
            for (int r = 0; r < N; r++) begin
                bitmap[r] <= '0;
            end
        end else if (accept) begin
            bitmap[yo][xo] <= 1'b1;
        end
    end

endmodule
